vga_sync_gen_module: RTL



---
 rtl/vga_timing_pkg.sv | 51 +++++
 rtl/vga_phase_fsm.sv | 46 ++++
 rtl/vga_sync_gen_module.sv | 123 ++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: phase encoding, default 800x600@60 timing
// and the 12-bit address width used by the sync generator and its phase FSMs.
package vga_timing_pkg;

  localparam int ADDR_W = 12;

  typedef enum logic [1:0] {
    PH_SYNC   = 2'd0,
    PH_BACK   = 2'd1,
    PH_ACTIVE = 2'd2,
    PH_FRONT  = 2'd3
  } phase_t;

  localparam int DEF_H_SYNC   = 128;
  localparam int DEF_H_BACK   = 88;
  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FRONT  = 40;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BACK   = 23;
  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FRONT  = 1;

  function automatic logic [ADDR_W-1:0] phase_len(
    input phase_t            ph,
    input logic [ADDR_W-1:0] len_sync,
    input logic [ADDR_W-1:0] len_back,
    input logic [ADDR_W-1:0] len_active,
    input logic [ADDR_W-1:0] len_front
  );
    logic [ADDR_W-1:0] len;
    case (ph)
      PH_SYNC:   len = len_sync;
      PH_BACK:   len = len_back;
      PH_ACTIVE: len = len_active;
      default:   len = len_front;
    endcase
    return len;
  endfunction

  function automatic phase_t next_phase(input phase_t ph);
    phase_t nxt;
    case (ph)
      PH_SYNC:   nxt = PH_BACK;
      PH_BACK:   nxt = PH_ACTIVE;
      PH_ACTIVE: nxt = PH_FRONT;
      default:   nxt = PH_SYNC;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/vga_phase_fsm.sv
// Four-phase (SYNC/BACK/ACTIVE/FRONT) counter FSM; one instance paces pixels
// within a line, the other paces lines within a frame.
module vga_phase_fsm
  import vga_timing_pkg::*;
#(
  parameter int SYNC_LEN   = DEF_H_SYNC,
  parameter int BACK_LEN   = DEF_H_BACK,
  parameter int ACTIVE_LEN = DEF_H_ACTIVE,
  parameter int FRONT_LEN  = DEF_H_FRONT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output phase_t            state,
  output logic [ADDR_W-1:0] count,
  output logic              last
);

  localparam logic [ADDR_W-1:0] SYNC_L   = ADDR_W'(SYNC_LEN);
  localparam logic [ADDR_W-1:0] BACK_L   = ADDR_W'(BACK_LEN);
  localparam logic [ADDR_W-1:0] ACTIVE_L = ADDR_W'(ACTIVE_LEN);
  localparam logic [ADDR_W-1:0] FRONT_L  = ADDR_W'(FRONT_LEN);

  logic [ADDR_W-1:0] cur_len;
  logic              at_end;

  assign cur_len = phase_len(state, SYNC_L, BACK_L, ACTIVE_L, FRONT_L);
  assign at_end  = (count == cur_len - ADDR_W'(1));
  // Final count of FRONT closes the whole period (line or frame).
  assign last    = at_end && (state == PH_FRONT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PH_SYNC;
      count <= '0;
    end else if (en) begin
      if (at_end) begin
        state <= next_phase(state);
        count <= '0;
      end else begin
        count <= count + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/vga_sync_gen_module.sv
// VGA sync/timing generator: HSYNC/VSYNC, pixel-valid and active-area addresses.
// Optional VGA_SYNC_FRAME_START_EN adds a one-clock Frame_Start_Sig pulse.
module vga_sync_gen_module
  import vga_timing_pkg::*;
#(
  parameter int   H_SYNC     = DEF_H_SYNC,
  parameter int   H_BACK     = DEF_H_BACK,
  parameter int   H_ACTIVE   = DEF_H_ACTIVE,
  parameter int   H_FRONT    = DEF_H_FRONT,
  parameter int   V_SYNC     = DEF_V_SYNC,
  parameter int   V_BACK     = DEF_V_BACK,
  parameter int   V_ACTIVE   = DEF_V_ACTIVE,
  parameter int   V_FRONT    = DEF_V_FRONT,
  parameter logic HS_POL     = 1'b1,
  parameter logic VS_POL     = 1'b1,
  parameter int   SYNC_DELAY = 1
) (
  input  logic              vga_clk,
  input  logic              rst_n,
  output logic              HSYNC_Sig,
  output logic              VSYNC_Sig,
  output logic              Ready_Sig,
  output logic [ADDR_W-1:0] Column_Addr_Sig,
  output logic [ADDR_W-1:0] Row_Addr_Sig
`ifdef VGA_SYNC_FRAME_START_EN
  ,
  output logic              Frame_Start_Sig
`endif
);

  localparam int STAGES = SYNC_DELAY + 1;

  phase_t            h_state;
  phase_t            v_state;
  logic [ADDR_W-1:0] h_count;
  logic [ADDR_W-1:0] v_count;
  logic              h_last;
  logic              v_last;
  logic              h_active;
  logic              v_active;
  logic              frame_end;
  logic [STAGES-1:0] hs_pipe;
  logic [STAGES-1:0] vs_pipe;

  vga_phase_fsm #(
    .SYNC_LEN   (H_SYNC),
    .BACK_LEN   (H_BACK),
    .ACTIVE_LEN (H_ACTIVE),
    .FRONT_LEN  (H_FRONT)
  ) h_fsm (
    .clk   (vga_clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .state (h_state),
    .count (h_count),
    .last  (h_last)
  );

  // Lines advance only on the final pixel clock of each line.
  vga_phase_fsm #(
    .SYNC_LEN   (V_SYNC),
    .BACK_LEN   (V_BACK),
    .ACTIVE_LEN (V_ACTIVE),
    .FRONT_LEN  (V_FRONT)
  ) v_fsm (
    .clk   (vga_clk),
    .rst_n (rst_n),
    .en    (h_last),
    .state (v_state),
    .count (v_count),
    .last  (v_last)
  );

  assign h_active  = (h_state == PH_ACTIVE);
  assign v_active  = (v_state == PH_ACTIVE);
  assign frame_end = h_last && v_last;

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      Ready_Sig       <= 1'b0;
      Column_Addr_Sig <= '0;
      Row_Addr_Sig    <= '0;
    end else begin
      Ready_Sig       <= h_active && v_active;
      Column_Addr_Sig <= h_active ? h_count : '0;
      Row_Addr_Sig    <= v_active ? v_count : '0;
    end
  end

  // Stage 0 matches the address latency; extra stages align with downstream colour.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_pipe <= {STAGES{~HS_POL}};
      vs_pipe <= {STAGES{~VS_POL}};
    end else begin
      for (int i = STAGES - 1; i > 0; i--) begin
        hs_pipe[i] <= hs_pipe[i-1];
        vs_pipe[i] <= vs_pipe[i-1];
      end
      hs_pipe[0] <= (h_state == PH_SYNC) ? HS_POL : ~HS_POL;
      vs_pipe[0] <= (v_state == PH_SYNC) ? VS_POL : ~VS_POL;
    end
  end

  assign HSYNC_Sig = hs_pipe[STAGES-1];
  assign VSYNC_Sig = vs_pipe[STAGES-1];

`ifdef VGA_SYNC_FRAME_START_EN
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      Frame_Start_Sig <= 1'b0;
    end else begin
      Frame_Start_Sig <= h_active && v_active && (h_count == '0) && (v_count == '0);
    end
  end
`endif

  // A frame boundary must bring both FSMs back to line 0, pixel 0 together.
  assert property (@(posedge vga_clk) disable iff (!rst_n)
    frame_end |=> (h_state == PH_SYNC && h_count == '0 &&
                   v_state == PH_SYNC && v_count == '0));

endmodule
